// File: rtl/tensorcore_result_drain_pkg.sv
// Shared tile types for the tensor core result path.
// A tile is D[row][col] of raw FP16 bit patterns. The patterns are stored and moved, never interpreted.
package tc_pkg;

    localparam int FP16_W    = 16;
    localparam int TILE_ROWS = 4;
    localparam int TILE_COLS = 4;

    typedef logic [15:0] fp16_t;
    typedef fp16_t tile_row_t [TILE_COLS];
    typedef tile_row_t tile_t [TILE_ROWS];

    // Column 0 goes in the least significant bits.
    function automatic logic [TILE_COLS*FP16_W-1:0] pack_row(input tile_row_t row);
        logic [TILE_COLS*FP16_W-1:0] v;
        v = '0;
        for (int c = 0; c < TILE_COLS; c++) begin
            v[c*FP16_W +: FP16_W] = row[c];
        end
        return v;
    endfunction

endpackage

// File: rtl/tensorcore_result_drain_tile_fifo.sv
// Tile FIFO with DEPTH slots. Each slot holds one whole tile, and any row of any slot can be read.
// Full and empty come from the occupancy count, so pointer equality is never used to decide them.
module tc_tile_fifo
    import tc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1,
    localparam int RW    = $clog2(TILE_ROWS)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        i_push,
    input  logic [TILE_ROWS-1:0][TILE_COLS-1:0][FP16_W-1:0] i_wr_tile,
    input  logic                                        i_pop,
    input  logic [PW-1:0]                               i_rd_slot,
    input  logic [RW-1:0]                               i_rd_row,
    output logic [TILE_COLS*FP16_W-1:0]                 o_rd_data,
    output logic [PW-1:0]                               o_wr_ptr,
    output logic [PW-1:0]                               o_rd_ptr,
    output logic [CW-1:0]                               o_count,
    output logic                                        o_full,
    output logic                                        o_empty
);
    tile_t         r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage is not reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (i_push) begin
            for (int r = 0; r < TILE_ROWS; r++) begin
                for (int c = 0; c < TILE_COLS; c++) begin
                    r_mem[r_wr_ptr][r][c] <= i_wr_tile[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = pack_row(r_mem[i_rd_slot][i_rd_row]);
    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_count   = r_count;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/tensorcore_result_drain.sv
// Drains 4x4 FP16 result tiles from the tensor core. Tiles are streamed out one row per beat,
// free-slot credits go to the issue logic, and any tile dropped while the buffer is full is flagged.
module tensorcore_result_drain
    import tc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int FPW   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tc_valid,
    input  logic [ROWS-1:0][COLS-1:0][FPW-1:0] tc_d,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [COLS*FPW-1:0]                m_data,
    output logic [1:0]                         m_row,
    output logic                               m_last,
    output logic [$clog2(DEPTH):0]             free_slots,
    output logic                               overflow,
    input  logic                               clr_ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]       w_wr_ptr;
    logic [PW-1:0]       w_rd_ptr;
    logic [PW-1:0]       w_rd_ptr_nxt;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_count_nxt;
    logic                w_full;
    logic                w_empty;
    logic                w_xfer;
    logic                w_pop;
    logic                w_accept;
    logic                w_push;
    logic                w_drop;
    logic                w_bypass;
    logic [1:0]          w_row_nxt;
    logic [COLS*FPW-1:0] w_rd_data;
    logic [COLS*FPW-1:0] w_data_nxt;

    logic [1:0]          r_row_cnt;
    logic                r_m_valid;
    logic                r_m_last;
    logic [COLS*FPW-1:0] r_m_data;
    logic [CW-1:0]       r_free;
    logic                r_ovf;

    assign w_xfer   = r_m_valid && m_ready;
    assign w_pop    = w_xfer && !w_empty && (r_row_cnt == 2'(ROWS - 1));
    assign w_accept = !w_full || w_pop;
    assign w_push   = tc_valid && w_accept;
    assign w_drop   = tc_valid && !w_accept;

    assign w_row_nxt    = w_pop ? 2'd0 : (w_xfer ? r_row_cnt + 2'd1 : r_row_cnt);
    assign w_rd_ptr_nxt = w_pop ? w_rd_ptr + PW'(1) : w_rd_ptr;

    always_comb begin
        w_count_nxt = w_count;
        if (w_push && !w_pop)      w_count_nxt = w_count + CW'(1);
        else if (!w_push && w_pop) w_count_nxt = w_count - CW'(1);
    end

    tc_tile_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wr_tile (tc_d),
        .i_pop     (w_pop),
        .i_rd_slot (w_rd_ptr_nxt),
        .i_rd_row  (w_row_nxt),
        .o_rd_data (w_rd_data),
        .o_wr_ptr  (w_wr_ptr),
        .o_rd_ptr  (w_rd_ptr),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // The output registers load the next head row. If that row is the tile being captured on this
    // same edge, the FIFO has not stored it yet, so it is taken straight from tc_d.
    assign w_bypass   = w_push && (w_wr_ptr == w_rd_ptr_nxt);
    assign w_data_nxt = w_bypass ? tc_d[w_row_nxt] : w_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_cnt <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_free    <= CW'(DEPTH);
            r_ovf     <= 1'b0;
        end else begin
            r_row_cnt <= w_row_nxt;
            r_m_valid <= (w_count_nxt != '0);
            r_m_last  <= (w_row_nxt == 2'(ROWS - 1));
            r_m_data  <= w_data_nxt;
            r_free    <= CW'(DEPTH) - w_count_nxt;
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_row      = r_row_cnt;
    assign m_last     = r_m_last;
    assign free_slots = r_free;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_tensorcore_result_drain.sv
// Self-checking bench for tensorcore_result_drain. Expected row beats are queued when a tile is issued
// and compared when the DUT presents them. Inputs are driven and outputs sampled on the falling edge.
module tb_tensorcore_result_drain;
    typedef logic [3:0][3:0][15:0] tile_p;
    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  row;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tc_valid;
    tile_p       tc_d;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [1:0]  m_row;
    logic        m_last;
    logic [2:0]  free_slots;
    logic        overflow;
    logic        clr_ovf;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    tensorcore_result_drain #(.DEPTH(4), .ROWS(4), .COLS(4), .FPW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tc_valid   (tc_valid),
        .tc_d       (tc_d),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_row      (m_row),
        .m_last     (m_last),
        .free_slots (free_slots),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    function automatic tile_p mk_tile(input logic [15:0] base);
        tile_p t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = base + 16'(r * 4 + c);
        return t;
    endfunction

    function automatic void push_exp(input tile_p t);
        for (int r = 0; r < 4; r++)
            sb.push_back('{data: t[r], row: 2'(r), last: (r == 3)});
    endfunction

    task automatic test_reset();
        total++;
        if (m_valid !== 1'b0 || m_row !== 2'd0 || m_last !== 1'b0 || m_data !== 64'd0 ||
            free_slots !== 3'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got v=%b row=%0d last=%b data=%h free=%0d ovf=%b want 0/0/0/0/4/0",
                     m_valid, m_row, m_last, m_data, free_slots, overflow);
        end
    endtask

    task automatic test_single_tile();
        beat_t exp;
        tile_p t;
        t = mk_tile(16'h3C00);
        total++;
        if (free_slots !== 3'd4) begin bad++; $display("FAIL single_free_idle: got %0d want 4", free_slots); end
        tc_d = t; tc_valid = 1'b1; m_ready = 1'b1; push_exp(t);
        @(negedge clk);
        tc_valid = 1'b0;
        total++;
        if (free_slots !== 3'd3) begin bad++; $display("FAIL single_free_busy: got %0d want 3", free_slots); end
        total++;
        if (m_data !== 64'h3C03_3C02_3C01_3C00) begin
            bad++; $display("FAIL single_row0_data: got %h want 3c033c023c013c00", m_data);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (m_valid !== 1'b1) begin bad++; $display("FAIL single_valid: beat %0d got %b want 1", i, m_valid); end
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL single_beat: unexpected beat row=%0d", m_row); end
            else begin
                exp = sb.pop_front();
                if (m_data !== exp.data || m_row !== exp.row || m_last !== exp.last) begin
                    bad++;
                    $display("FAIL single_beat: got %h/%0d/%b want %h/%0d/%b",
                             m_data, m_row, m_last, exp.data, exp.row, exp.last);
                end
            end
            @(negedge clk);
        end
        total++;
        if (m_valid !== 1'b0 || free_slots !== 3'd4) begin
            bad++; $display("FAIL single_done: got v=%b free=%0d want 0/4", m_valid, free_slots);
        end
    endtask

    task automatic test_fill_overflow();
        beat_t exp;
        tile_p t;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = mk_tile(16'h1000 * 16'(i + 1));
            tc_d = t; tc_valid = 1'b1; push_exp(t);
            @(negedge clk);
        end
        total++;
        if (free_slots !== 3'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL fill_full: got free=%0d ovf=%b want 0/0", free_slots, overflow);
        end
        tc_d = mk_tile(16'h7000);
        @(negedge clk);
        tc_valid = 1'b0;
        total++;
        if (overflow !== 1'b1 || free_slots !== 3'd0) begin
            bad++; $display("FAIL fill_drop: got ovf=%b free=%0d want 1/0", overflow, free_slots);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (m_valid !== 1'b1 || sb.size() == 0) begin
                bad++; $display("FAIL fill_beat: beat %0d got valid=%b want 1", i, m_valid);
            end else begin
                exp = sb.pop_front();
                if (m_data !== exp.data || m_row !== exp.row || m_last !== exp.last) begin
                    bad++;
                    $display("FAIL fill_beat: beat %0d got %h/%0d/%b want %h/%0d/%b",
                             i, m_data, m_row, m_last, exp.data, exp.row, exp.last);
                end
            end
            @(negedge clk);
        end
        total++;
        if (m_valid !== 1'b0 || sb.size() != 0) begin
            bad++; $display("FAIL fill_extra: got valid=%b pending=%0d want 0/0", m_valid, sb.size());
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL fill_clear: got ovf=%b want 0", overflow); end
    endtask

    task automatic test_full_pop_push();
        beat_t exp;
        tile_p t;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = mk_tile(16'h2000 + 16'h0100 * 16'(i));
            tc_d = t; tc_valid = 1'b1; push_exp(t);
            @(negedge clk);
        end
        tc_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                t = mk_tile(16'h2800);
                tc_d = t; tc_valid = 1'b1;
            end
            total++;
            exp = sb.pop_front();
            if (m_data !== exp.data || m_row !== exp.row || m_last !== exp.last) begin
                bad++;
                $display("FAIL popfill_beat: got %h/%0d/%b want %h/%0d/%b",
                         m_data, m_row, m_last, exp.data, exp.row, exp.last);
            end
            if (i == 3) push_exp(t);
            @(negedge clk);
        end
        tc_valid = 1'b0;
        total++;
        if (overflow !== 1'b0 || free_slots !== 3'd0) begin
            bad++; $display("FAIL popfill_accept: got ovf=%b free=%0d want 0/0", overflow, free_slots);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (m_valid !== 1'b1 || sb.size() == 0) begin
                bad++; $display("FAIL popfill_drain: beat %0d got valid=%b want 1", i, m_valid);
            end else begin
                exp = sb.pop_front();
                if (m_data !== exp.data || m_row !== exp.row || m_last !== exp.last) begin
                    bad++;
                    $display("FAIL popfill_drain: beat %0d got %h/%0d/%b want %h/%0d/%b",
                             i, m_data, m_row, m_last, exp.data, exp.row, exp.last);
                end
            end
            @(negedge clk);
        end
        total++;
        if (m_valid !== 1'b0 || free_slots !== 3'd4) begin
            bad++; $display("FAIL popfill_end: got v=%b free=%0d want 0/4", m_valid, free_slots);
        end
    endtask

    task automatic test_random();
        beat_t       exp;
        tile_p       t;
        int          sent = 0;
        int          rcvd = 0;
        int          cyc  = 0;
        logic        pstall = 1'b0;
        logic [63:0] pdata = '0;
        logic [1:0]  prow = '0;
        logic        plast = 1'b0;
        logic        rdy;
        logic        tcv;
        while (rcvd < 80 && cyc < 3000) begin
            if (pstall) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== pdata || m_row !== prow || m_last !== plast) begin
                    bad++;
                    $display("FAIL rand_hold: got %b/%h/%0d/%b want 1/%h/%0d/%b",
                             m_valid, m_data, m_row, m_last, pdata, prow, plast);
                end
            end
            rdy = 1'($urandom_range(0, 1));
            tcv = (sent < 20) && (free_slots != 3'd0) && ($urandom_range(0, 1) == 1);
            if (tcv) begin
                t = mk_tile(16'($urandom));
                push_exp(t);
                tc_d = t;
                sent++;
            end
            tc_valid = tcv;
            m_ready  = rdy;
            if (m_valid === 1'b1 && rdy) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL rand_beat: unexpected beat row=%0d", m_row); end
                else begin
                    exp = sb.pop_front();
                    if (m_data !== exp.data || m_row !== exp.row || m_last !== exp.last) begin
                        bad++;
                        $display("FAIL rand_beat: beat %0d got %h/%0d/%b want %h/%0d/%b",
                                 rcvd, m_data, m_row, m_last, exp.data, exp.row, exp.last);
                    end
                end
                rcvd++;
            end
            pstall = (m_valid === 1'b1) && !rdy;
            pdata  = m_data;
            prow   = m_row;
            plast  = m_last;
            @(negedge clk);
            cyc++;
        end
        tc_valid = 1'b0;
        m_ready  = 1'b0;
        total++;
        if (rcvd != 80) begin bad++; $display("FAIL rand_timeout: got %0d beats want 80", rcvd); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL rand_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        beat_t exp;
        tile_p t;
        m_ready = 1'b1;
        t = mk_tile(16'h5000);
        tc_d = t; tc_valid = 1'b1; push_exp(t);
        @(negedge clk);
        tc_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            exp = sb.pop_front();
            if (m_data !== exp.data || m_row !== exp.row || m_last !== exp.last) begin
                bad++;
                $display("FAIL rstmid_beat: got %h/%0d/%b want %h/%0d/%b",
                         m_data, m_row, m_last, exp.data, exp.row, exp.last);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || free_slots !== 3'd4 || m_row !== 2'd0) begin
            bad++; $display("FAIL rstmid_async: got v=%b free=%0d row=%0d want 0/4/0", m_valid, free_slots, m_row);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        t = mk_tile(16'h6000);
        tc_d = t; tc_valid = 1'b1; push_exp(t);
        @(negedge clk);
        tc_valid = 1'b0;
        total++;
        if (m_valid !== 1'b1 || m_row !== 2'd0) begin
            bad++; $display("FAIL rstmid_restart: got v=%b row=%0d want 1/0", m_valid, m_row);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            exp = sb.pop_front();
            if (m_data !== exp.data || m_row !== exp.row || m_last !== exp.last) begin
                bad++;
                $display("FAIL rstmid_after: got %h/%0d/%b want %h/%0d/%b",
                         m_data, m_row, m_last, exp.data, exp.row, exp.last);
            end
            @(negedge clk);
        end
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_end: got v=%b want 0", m_valid); end
    endtask

    task automatic test_ovf_clear();
        beat_t exp;
        tile_p t;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = mk_tile(16'h4000 + 16'h0040 * 16'(i));
            tc_d = t; tc_valid = 1'b1; push_exp(t);
            @(negedge clk);
        end
        tc_d = mk_tile(16'h7100);
        @(negedge clk);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        tc_d = mk_tile(16'h7200); clr_ovf = 1'b1;
        @(negedge clk);
        tc_valid = 1'b0;
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_drop_wins: got %b want 1", overflow); end
        @(negedge clk);
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (m_valid !== 1'b1 || sb.size() == 0) begin
                bad++; $display("FAIL ovf_drain: beat %0d got valid=%b want 1", i, m_valid);
            end else begin
                exp = sb.pop_front();
                if (m_data !== exp.data || m_row !== exp.row || m_last !== exp.last) begin
                    bad++;
                    $display("FAIL ovf_drain: beat %0d got %h/%0d/%b want %h/%0d/%b",
                             i, m_data, m_row, m_last, exp.data, exp.row, exp.last);
                end
            end
            @(negedge clk);
        end
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL ovf_end: got v=%b want 0", m_valid); end
    endtask

    initial begin
        rst_n    = 1'b0;
        tc_valid = 1'b0;
        tc_d     = '0;
        m_ready  = 1'b0;
        clr_ovf  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single_tile();
        test_fill_overflow();
        test_full_pop_push();
        test_random();
        test_reset_mid();
        test_ovf_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
